probe_lookup: RTL and testbench
===============================

PROBE_LOOKUP -- requirements
Module: probe_lookup

Interface
REQ-001 Parameter PEND_DEPTH, default 32: depth of pending-key FIFO (power of two).
REQ-002 Parameter MATCH_DEPTH, default 32: depth of match output FIFO (power of two).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 done  out  1  all input consumed, all lookups resolved, match FIFO empty.
REQ-006 table_base_in  in  48  byte address of hash table; static after reset release.
REQ-007 upstream_done_in  in  1  upstream stage has produced its last row.
REQ-008 input_empty_in  in  1  upstream FIFO empty (first-word-fall-through).
REQ-009 input_read_en_out  out  1  pop upstream; value/hash valid same cycle.
REQ-010 input_value_in  in  64  probe key.
REQ-011 input_hash_in  in  64  masked hash of probe key.
REQ-012 tbl_rq_stall_in  in  1  memory cannot accept a request this cycle.
REQ-013 tbl_rq_vld_out  out  1  table read request valid.
REQ-014 tbl_rq_vadr_out  out  48  table read byte address.
REQ-015 tbl_rs_stall_out  out  1  response back-pressure; constant 0.
REQ-016 tbl_rs_vld_in  in  1  table read response valid.
REQ-017 tbl_rs_data_in  in  64  stored key of addressed entry.
REQ-018 match_empty_out  out  1  match FIFO empty.
REQ-019 match_read_en_in  in  1  pop match FIFO (FWFT).
REQ-020 match_value_out  out  64  matched key at head of match FIFO.
REQ-021 match_count_out  out  64  total matches found.
REQ-022 miss_count_out  out  64  total misses found.

Function
REQ-023 Table entries are 8 bytes; address = table_base_in + (input_hash_in << 3), truncated to 48 bits.
REQ-024 Memory returns responses in request order, one response per accepted request.
REQ-025 Request register: tbl_rq_vld_out/vadr_out registered; while vld=1 and stall=1, both held unchanged; request accepted on a cycle with vld=1, stall=0.
REQ-026 input_read_en_out = state RUN && !input_empty_in && credit_ok && (!tbl_rq_vld_out || !tbl_rq_stall_in), combinational.
REQ-027 credit_ok = (outstanding + match occupancy) < MATCH_DEPTH-1 and pending FIFO not full; outstanding counts popped-but-unanswered keys.
REQ-028 On pop: key pushed into pending FIFO same cycle; request appears on tbl_rq_* next cycle (latency 1).
REQ-029 On tbl_rs_vld_in: pop pending FIFO; if rs_data == popped key and rs_data != 0, push key into match FIFO and increment match_count; else increment miss_count (key 0 always a miss).
REQ-030 Response-to-match_empty_out deassert latency: 1 cycle.
REQ-031 Simultaneous pop-upstream and response in one cycle: outstanding unchanged; both FIFOs updated correctly.
REQ-032 Simultaneous match push and pop: occupancy unchanged; pop with match_empty_out=1 ignored.
REQ-033 Counters 64-bit, wrap modulo 2^64.
REQ-034 FSM RUN -> DRAIN when upstream_done_in && input_empty_in; DRAIN -> DONE when outstanding=0 and tbl_rq_vld_out=0; DONE holds until reset.
REQ-035 done = (state DONE) && match_empty_out.
REQ-036 tbl_rs_vld_in with outstanding=0 is a protocol error: ignored, counters unchanged.

Reset
REQ-037 Reset asserted: state RUN, FIFOs empty, outstanding=0, counters 0, tbl_rq_vld_out=0, tbl_rq_vadr_out=0, input_read_en_out=0, match_empty_out=1, done=0.
REQ-038 Reset mid-operation discards all pending and matched keys; in-flight memory responses after release are the environment's responsibility.

Structure
REQ-039 Package probe_pkg holds ADDR_W=48, DATA_W=64, ENTRY_SHIFT=3, FSM state type (RUN, DRAIN, DONE).
REQ-040 One sub-module probe_fifo (FWFT synchronous FIFO, parameter depth/width, empty/full/count), instanced for pending and match.

Verification
REQ-041 base=0x1000, hash=5, key=0x77, response 0x77 -> vadr 0x1028, match_value 0x77, match_count 1.
REQ-042 Keys 1..4, responses 1,9,3,0 -> matches 1,3 in order; match_count 2, miss_count 2.
REQ-043 tbl_rq_stall_in high 10 cycles during stream -> vld/vadr held stable, no request lost or duplicated.
REQ-044 match_read_en_in low, 100 hits -> input pops stop with outstanding+occupancy=31; no overflow; resume on drain.
REQ-045 upstream_done_in with 3 outstanding -> DRAIN; done rises 1 cycle after last match popped.
REQ-046 rst low mid-stream with 5 outstanding -> all outputs at reset values asynchronously; counters 0.

Source files
------------

// File: rtl/probe_pkg.sv
// rtl/probe_pkg.sv - shared widths, FSM state type and table address helper for probe_lookup
package probe_pkg;

    localparam int ADDR_W      = 48;
    localparam int DATA_W      = 64;
    localparam int ENTRY_SHIFT = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } probe_state_t;

    // Byte address of the 8-byte table entry selected by a hash, modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] entry_addr(
        input logic [ADDR_W-1:0] base,
        input logic [DATA_W-1:0] hash
    );
        logic [ADDR_W-1:0] offset;
        offset = ADDR_W'(hash << ENTRY_SHIFT);
        return base + offset;
    endfunction

endpackage

// File: rtl/probe_fifo.sv
// rtl/probe_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module probe_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty FIFO is dropped; a push into a full FIFO only lands if a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (count == '0);
    assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/probe_lookup.sv
// rtl/probe_lookup.sv - hash-table probe: issues table reads per key, emits keys whose stored entry matches
module probe_lookup
    import probe_pkg::*;
#(
    parameter int PEND_DEPTH  = 32,
    parameter int MATCH_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              done,
    input  logic [47:0]       table_base_in,
    input  logic              upstream_done_in,
    input  logic              input_empty_in,
    output logic              input_read_en_out,
    input  logic [63:0]       input_value_in,
    input  logic [63:0]       input_hash_in,
    input  logic              tbl_rq_stall_in,
    output logic              tbl_rq_vld_out,
    output logic [47:0]       tbl_rq_vadr_out,
    output logic              tbl_rs_stall_out,
    input  logic              tbl_rs_vld_in,
    input  logic [63:0]       tbl_rs_data_in,
    output logic              match_empty_out,
    input  logic              match_read_en_in,
    output logic [63:0]       match_value_out,
    output logic [63:0]       match_count_out,
    output logic [63:0]       miss_count_out
);

    localparam int PCW = $clog2(PEND_DEPTH) + 1;
    localparam int MCW = $clog2(MATCH_DEPTH) + 1;

    probe_state_t     state;

    logic [PCW-1:0]   pend_count;
    logic             pend_empty;
    logic             pend_full;
    logic [DATA_W-1:0] pend_head;

    logic [MCW-1:0]   match_fill;
    logic             match_full;

    logic [31:0]      inflight;
    logic             credit_ok;
    logic             rq_slot_free;
    logic             rs_take;
    logic             is_match;

    // Responses are never back-pressured; the credit scheme guarantees room for every match.
    assign tbl_rs_stall_out = 1'b0;

    // Every popped key sits in the pending FIFO until its response returns, so the pending
    // occupancy is exactly the number of outstanding lookups.
    assign inflight  = 32'(pend_count) + 32'(match_fill);
    assign credit_ok = (inflight < 32'(MATCH_DEPTH - 1)) && !pend_full && !match_full;

    // The request register can take a new address when empty or when its current request is accepted.
    assign rq_slot_free = !tbl_rq_vld_out || !tbl_rq_stall_in;

    // Gated by reset so the pop strobe is low while reset is held, not only after the first edge.
    assign input_read_en_out = rst && (state == RUN) && !input_empty_in && credit_ok && rq_slot_free;

    // A response with nothing outstanding is a protocol error and is dropped.
    assign rs_take  = tbl_rs_vld_in && !pend_empty;
    assign is_match = rs_take && (tbl_rs_data_in == pend_head) && (tbl_rs_data_in != '0);

    assign done = (state == DONE) && match_empty_out;

    probe_fifo #(
        .DEPTH (PEND_DEPTH),
        .WIDTH (DATA_W)
    ) u_pend_fifo (
        .clk       (clk),
        .resetn    (rst),
        .push      (input_read_en_out),
        .push_data (input_value_in),
        .pop       (rs_take),
        .head      (pend_head),
        .empty     (pend_empty),
        .full      (pend_full),
        .count     (pend_count)
    );

    probe_fifo #(
        .DEPTH (MATCH_DEPTH),
        .WIDTH (DATA_W)
    ) u_match_fifo (
        .clk       (clk),
        .resetn    (rst),
        .push      (is_match),
        .push_data (tbl_rs_data_in),
        .pop       (match_read_en_in),
        .head      (match_value_out),
        .empty     (match_empty_out),
        .full      (match_full),
        .count     (match_fill)
    );

    // Request register: load on an upstream pop, hold while stalled, clear once accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_rq_vld_out  <= 1'b0;
            tbl_rq_vadr_out <= '0;
        end else if (input_read_en_out) begin
            tbl_rq_vld_out  <= 1'b1;
            tbl_rq_vadr_out <= entry_addr(table_base_in, input_hash_in);
        end else if (!tbl_rq_stall_in) begin
            tbl_rq_vld_out  <= 1'b0;
        end
    end

    // Hit/miss statistics; a zero key never counts as a hit since zero marks an empty slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_count_out <= '0;
            miss_count_out  <= '0;
        end else if (rs_take) begin
            if (is_match) begin
                match_count_out <= match_count_out + 64'd1;
            end else begin
                miss_count_out  <= miss_count_out + 64'd1;
            end
        end
    end

    // Run until upstream is exhausted, drain outstanding lookups, then park in DONE until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (upstream_done_in && input_empty_in) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pend_empty && !tbl_rq_vld_out) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_probe_lookup.sv
// tb/tb_probe_lookup.sv - scoreboard bench for probe_lookup
module tb_probe_lookup;

    logic        clk;
    logic        rst;
    logic        done;
    logic [47:0] table_base_in;
    logic        upstream_done_in;
    logic        input_empty_in;
    logic        input_read_en_out;
    logic [63:0] input_value_in;
    logic [63:0] input_hash_in;
    logic        tbl_rq_stall_in;
    logic        tbl_rq_vld_out;
    logic [47:0] tbl_rq_vadr_out;
    logic        tbl_rs_stall_out;
    logic        tbl_rs_vld_in;
    logic [63:0] tbl_rs_data_in;
    logic        match_empty_out;
    logic        match_read_en_in;
    logic [63:0] match_value_out;
    logic [63:0] match_count_out;
    logic [63:0] miss_count_out;

    probe_lookup dut (
        .clk               (clk),
        .rst               (rst),
        .done              (done),
        .table_base_in     (table_base_in),
        .upstream_done_in  (upstream_done_in),
        .input_empty_in    (input_empty_in),
        .input_read_en_out (input_read_en_out),
        .input_value_in    (input_value_in),
        .input_hash_in     (input_hash_in),
        .tbl_rq_stall_in   (tbl_rq_stall_in),
        .tbl_rq_vld_out    (tbl_rq_vld_out),
        .tbl_rq_vadr_out   (tbl_rq_vadr_out),
        .tbl_rs_stall_out  (tbl_rs_stall_out),
        .tbl_rs_vld_in     (tbl_rs_vld_in),
        .tbl_rs_data_in    (tbl_rs_data_in),
        .match_empty_out   (match_empty_out),
        .match_read_en_in  (match_read_en_in),
        .match_value_out   (match_value_out),
        .match_count_out   (match_count_out),
        .miss_count_out    (miss_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] key;
        logic [63:0] hash;
    } up_t;

    up_t         up_q[$];
    logic [47:0] exp_adr_q[$];
    logic [63:0] rsp_q[$];
    logic [63:0] exp_match_q[$];

    int          vectors;
    int          miscompares;
    int          acc_cnt;
    int          pop_cnt;
    logic [63:0] exp_mc;
    logic [63:0] exp_mm;
    logic [47:0] base;
    bit          mem_hold;
    bit          mrd;
    bit          stall_force;
    bit          stray;
    bit          rsp_now;
    logic [47:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_key(input logic [63:0] key, input logic [63:0] hash, input logic [63:0] rsp);
        up_t         e;
        logic [63:0] full_adr;
        e.key  = key;
        e.hash = hash;
        up_q.push_back(e);
        full_adr = {16'h0, base} + hash * 64'd8;
        exp_adr_q.push_back(full_adr[47:0]);
        rsp_q.push_back(rsp);
        if (rsp == key && rsp != 64'd0) begin
            exp_match_q.push_back(key);
            exp_mc = exp_mc + 64'd1;
        end else begin
            exp_mm = exp_mm + 64'd1;
        end
    endtask

    task automatic drive();
        input_empty_in   = (up_q.size() == 0);
        input_value_in   = (up_q.size() == 0) ? 64'd0 : up_q[0].key;
        input_hash_in    = (up_q.size() == 0) ? 64'd0 : up_q[0].hash;
        tbl_rq_stall_in  = stall_force;
        match_read_en_in = mrd;
        rsp_now          = 1'b0;
        tbl_rs_vld_in    = 1'b0;
        tbl_rs_data_in   = 64'd0;
        if (!mem_hold && acc_cnt > 0) begin
            rsp_now        = 1'b1;
            tbl_rs_vld_in  = 1'b1;
            tbl_rs_data_in = rsp_q[0];
        end else if (stray) begin
            tbl_rs_vld_in  = 1'b1;
            tbl_rs_data_in = 64'h1234;
        end
    endtask

    // One clock: drive at the falling edge, score what the rising edge will consume, update models.
    task automatic step();
        bit pop;
        bit acc;
        bit mpop;
        drive();
        #1;
        pop  = input_read_en_out;
        acc  = tbl_rq_vld_out && !tbl_rq_stall_in;
        mpop = match_read_en_in && !match_empty_out;
        if (acc) begin
            if (exp_adr_q.size() == 0) check("extra_request", 64'(tbl_rq_vadr_out), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("vadr", 64'(tbl_rq_vadr_out), 64'(exp_adr_q.pop_front()));
        end
        if (mpop) begin
            if (exp_match_q.size() == 0) check("extra_match", match_value_out, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("match_value", match_value_out, exp_match_q.pop_front());
        end
        @(posedge clk);
        if (pop && up_q.size() > 0) begin
            void'(up_q.pop_front());
            pop_cnt++;
        end
        if (rsp_now) begin
            void'(rsp_q.pop_front());
            acc_cnt--;
        end
        if (acc) acc_cnt++;
        @(negedge clk);
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (!(up_q.size() == 0 && acc_cnt == 0 && exp_adr_q.size() == 0 &&
                 (exp_match_q.size() == 0 || !mrd)) && n < budget) begin
            step();
            n++;
        end
        check("idle_in_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_match_count"}, match_count_out, exp_mc);
        check({tag, "_miss_count"}, miss_count_out, exp_mm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0; acc_cnt = 0; pop_cnt = 0;
        exp_mc = 0; exp_mm = 0;
        base = 48'h1000;
        mem_hold = 0; mrd = 0; stall_force = 0; stray = 0; rsp_now = 0;
        table_base_in    = base;
        upstream_done_in = 1'b0;
        input_empty_in   = 1'b0;
        input_value_in   = 64'h55;
        input_hash_in    = 64'h3;
        tbl_rq_stall_in  = 1'b0;
        tbl_rs_vld_in    = 1'b0;
        tbl_rs_data_in   = 64'd0;
        match_read_en_in = 1'b0;
        rst = 1'b0;

        // Reset state, with upstream presenting data
        repeat (2) @(negedge clk);
        check("rst_rq_vld", 64'(tbl_rq_vld_out), 64'd0);
        check("rst_rq_vadr", 64'(tbl_rq_vadr_out), 64'd0);
        check("rst_read_en", 64'(input_read_en_out), 64'd0);
        check("rst_match_empty", 64'(match_empty_out), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rs_stall", 64'(tbl_rs_stall_out), 64'd0);
        check_counts("rst");
        input_empty_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);

        // Single hit: latency of request and of match visibility
        push_key(64'h77, 64'd5, 64'h77);
        step();
        check("lat_rq_vld", 64'(tbl_rq_vld_out), 64'd1);
        check("lat_rq_vadr", 64'(tbl_rq_vadr_out), 64'h1028);
        step();
        check("lat_match_empty_before", 64'(match_empty_out), 64'd1);
        step();
        check("lat_match_empty_after", 64'(match_empty_out), 64'd0);
        check("lat_match_head", match_value_out, 64'h77);
        mrd = 1;
        run_idle(50);
        check_counts("single");

        // Mixed hits and misses, including key 0 with a zero response
        push_key(64'd1, 64'd3, 64'd1);
        push_key(64'd2, 64'd6, 64'd9);
        push_key(64'd3, 64'd9, 64'd3);
        push_key(64'd4, 64'd12, 64'd0);
        push_key(64'd0, 64'd7, 64'd0);
        run_idle(100);
        check_counts("mixed");

        // Stray response with nothing outstanding is ignored
        stray = 1;
        step();
        stray = 0;
        step();
        check_counts("stray");
        check("stray_match_empty", 64'(match_empty_out), 64'd1);

        // Request stall for 10 cycles mid-stream, with wide hashes exercising address truncation
        for (int i = 0; i < 20; i++) begin
            logic [63:0] k;
            k = 64'h100 + 64'(i);
            push_key(k, {$urandom, $urandom}, (i % 2 == 0) ? k : k + 64'd1);
        end
        for (int i = 0; i < 40; i++) begin
            stall_force = (i >= 3 && i < 13);
            step();
            if (i == 3) begin
                held = tbl_rq_vadr_out;
                check("stall_vld", 64'(tbl_rq_vld_out), 64'd1);
            end else if (i > 3 && i < 13) begin
                check("stall_vld", 64'(tbl_rq_vld_out), 64'd1);
                check("stall_vadr", 64'(tbl_rq_vadr_out), 64'(held));
            end
        end
        stall_force = 0;
        run_idle(200);
        check_counts("stall");

        // Match FIFO back-pressure: pops stop at 31 in flight, resume on drain
        mrd = 0;
        pop_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            logic [63:0] k;
            k = 64'h2000 + 64'(i);
            push_key(k, {$urandom, $urandom}, k);
        end
        repeat (150) step();
        check("bp_pops", 64'(pop_cnt), 64'd31);
        check("bp_match_empty", 64'(match_empty_out), 64'd0);
        mrd = 1;
        run_idle(800);
        check("bp_all_popped", 64'(pop_cnt), 64'd100);
        check_counts("bp");

        // Upstream done with 3 lookups outstanding, then done after last match pops
        mrd = 0;
        mem_hold = 1;
        push_key(64'hA1, 64'd21, 64'hA1);
        push_key(64'hA2, 64'd22, 64'hA2);
        push_key(64'hA3, 64'd23, 64'hA3);
        repeat (10) step();
        check("drain_reqs_issued", 64'(exp_adr_q.size()), 64'd0);
        check("drain_outstanding", 64'(acc_cnt), 64'd3);
        upstream_done_in = 1'b1;
        repeat (3) step();
        check("drain_done_early", 64'(done), 64'd0);
        mem_hold = 0;
        repeat (6) step();
        check("drain_done_matches_held", 64'(done), 64'd0);
        check_counts("drain");
        mrd = 1;
        step();
        step();
        check("drain_done_before_last", 64'(done), 64'd0);
        step();
        check("drain_done_after_last", 64'(done), 64'd1);
        mrd = 0;
        step();
        check("drain_done_holds", 64'(done), 64'd1);

        // Fresh run, then asynchronous reset with 5 lookups outstanding
        rst = 1'b0;
        up_q.delete(); exp_adr_q.delete(); rsp_q.delete(); exp_match_q.delete();
        acc_cnt = 0; exp_mc = 0; exp_mm = 0; upstream_done_in = 1'b0;
        mem_hold = 0; mrd = 0;
        repeat (2) step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) push_key(64'hB1 + 64'(i), 64'(40 + i), 64'hB1 + 64'(i));
        repeat (15) step();
        check("pre_rst_match_count", match_count_out, 64'd4);
        mem_hold = 1;
        for (int i = 0; i < 5; i++) push_key(64'hC1 + 64'(i), 64'(50 + i), 64'hC1 + 64'(i));
        repeat (12) step();
        check("pre_rst_outstanding", 64'(acc_cnt), 64'd5);
        input_empty_in = 1'b0;
        input_value_in = 64'hC0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_rq_vld", 64'(tbl_rq_vld_out), 64'd0);
        check("arst_rq_vadr", 64'(tbl_rq_vadr_out), 64'd0);
        check("arst_read_en", 64'(input_read_en_out), 64'd0);
        check("arst_match_empty", 64'(match_empty_out), 64'd1);
        check("arst_done", 64'(done), 64'd0);
        check("arst_match_count", match_count_out, 64'd0);
        check("arst_miss_count", miss_count_out, 64'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
